// File: rtl/vga_pkg.sv
// Shared VGA sprite types: fetch FSM states, sprite data width, and the
// default sprite RAM base address.
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      ISSUE,
      WAIT
   } fetch_state_t;

   localparam int SPR_DATA_W = 16;

   localparam logic [8:0] SPRITE_MEM_LOC = 9'h0a0;

endpackage

// File: rtl/sprite_next_sel.sv
// Priority encoder: lowest set bit of a pending mask.
// Ports: i_pend (mask in), o_found (any bit set), o_next_idx (lowest index).
module sprite_next_sel #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_pend,
   output logic          o_found,
   output logic [IW-1:0] o_next_idx
);

   // Scan from the top down so the lowest set bit is written last.
   always_comb begin
      o_found    = 1'b0;
      o_next_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_pend[i]) begin
            o_found    = 1'b1;
            o_next_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite row fetcher: on linebegin it walks enabled sprites in
// index order, reads each row from sprite RAM and strobes it out on line_en.
// Ports: px_clk/rst clock+sync reset; linebegin start pulse; spr_addr/spr_en
// per-sprite row address and enable; ram_addr/ram_rd/ram_rdata RAM port;
// line_data/line_en row delivery; busy walk active; overrun/overrun_clr
// sticky restart flag and its clear.
module sprite_line_fetch
   import vga_pkg::*;
#(
   parameter int NSPR   = 4,
   parameter int RD_LAT = 1,
   parameter int AW     = 9
) (
   input  logic                  px_clk,
   input  logic                  rst,
   input  logic                  linebegin,
   input  logic [NSPR*AW-1:0]    spr_addr,
   input  logic [NSPR-1:0]       spr_en,
   output logic [AW-1:0]         ram_addr,
   output logic                  ram_rd,
   input  logic [SPR_DATA_W-1:0] ram_rdata,
   output logic [SPR_DATA_W-1:0] line_data,
   output logic [NSPR-1:0]       line_en,
   output logic                  busy,
   output logic                  overrun,
   input  logic                  overrun_clr
);

   localparam int IW = (NSPR > 1) ? $clog2(NSPR) : 1;
   localparam int CW = $clog2(RD_LAT + 1);

   fetch_state_t          r_state;
   fetch_state_t          w_state_nx;
   logic [IW-1:0]         r_idx;
   logic [IW-1:0]         w_idx_nx;
   logic [NSPR-1:0]       r_pend;
   logic [NSPR-1:0]       w_pend_nx;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nx;
   logic [SPR_DATA_W-1:0] r_line_data;
   logic [NSPR-1:0]       r_line_en;
   logic                  r_overrun;

   logic [NSPR-1:0]       w_idx_oh;
   logic [NSPR-1:0]       w_sel_in;
   logic                  w_found;
   logic [IW-1:0]         w_next_idx;
   logic                  w_last;
   logic                  w_cap;
   logic                  w_abort;

   assign w_idx_oh = NSPR'(1) << r_idx;
   assign w_last   = (r_cnt == CW'(1));

   // SETTLE picks the first sprite straight from spr_en (pend is being
   // loaded that same cycle); WAIT picks the next one after dropping idx.
   assign w_sel_in = (r_state == SETTLE) ? spr_en
                                         : (r_pend & ~w_idx_oh);

   sprite_next_sel #(
      .N  (NSPR),
      .IW (IW)
   ) u_next_sel (
      .i_pend     (w_sel_in),
      .o_found    (w_found),
      .o_next_idx (w_next_idx)
   );

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_pend_nx  = r_pend;
      w_cnt_nx   = r_cnt;
      w_cap      = 1'b0;
      w_abort    = 1'b0;
      if (linebegin) begin
         // A new line always restarts; mid-walk it also drops any capture.
         w_abort    = (r_state != IDLE);
         w_state_nx = SETTLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               w_state_nx = IDLE;
            end
            SETTLE: begin
               w_pend_nx = spr_en;
               if (w_found) begin
                  w_idx_nx   = w_next_idx;
                  w_state_nx = ISSUE;
               end else begin
                  w_state_nx = IDLE;
               end
            end
            ISSUE: begin
               w_cnt_nx   = CW'(RD_LAT);
               w_state_nx = WAIT;
            end
            WAIT: begin
               w_cnt_nx = r_cnt - CW'(1);
               if (w_last) begin
                  w_cap     = 1'b1;
                  w_pend_nx = r_pend & ~w_idx_oh;
                  if (w_found) begin
                     w_idx_nx   = w_next_idx;
                     w_state_nx = ISSUE;
                  end else begin
                     w_state_nx = IDLE;
                  end
               end
            end
            default: begin
               w_state_nx = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge px_clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_pend      <= '0;
         r_cnt       <= '0;
         r_line_data <= '0;
         r_line_en   <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_idx     <= w_idx_nx;
         r_pend    <= w_pend_nx;
         r_cnt     <= w_cnt_nx;
         r_line_en <= w_cap ? w_idx_oh : '0;
         if (w_cap) begin
            r_line_data <= ram_rdata;
         end
         // Set has priority over clear.
         if (w_abort) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign ram_addr  = spr_addr[int'(r_idx)*AW +: AW];
   assign ram_rd    = (r_state == ISSUE);
   assign busy      = (r_state != IDLE);
   assign line_data = r_line_data;
   assign line_en   = r_line_en;
   assign overrun   = r_overrun;

endmodule

// File: doc/sprite_line_fetch.md
# sprite_line_fetch

Per-scanline sprite bitmap fetcher that sits directly upstream of the pong sprite engines. On each `linebegin` it walks the enabled sprites in index order, reads each sprite's current 16-bit bitmap row from the shared sprite RAM at the address that sprite presents (`mem_addr`), and delivers it over a shared `line_data` bus with a one-hot `line_en` strobe. Fetching completes inside horizontal blanking, so each sprite's line register is stable for the whole visible line.

## Interface
Parameters:
- `NSPR`, 4: number of sprite engines served (1..8).
- `RD_LAT`, 1: sprite RAM read latency in px_clk cycles (1..3).
- `AW`, 9: sprite RAM address width.

Ports:
- `px_clk`  in  1  pixel clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `linebegin`  in  1  one-cycle pulse at start of horizontal blanking.
- `spr_addr`  in  NSPR*AW  flattened row addresses; sprite i at bits [i*AW +: AW].
- `spr_en`  in  NSPR  per-sprite fetch enable.
- `ram_addr`  out  AW  sprite RAM read address.
- `ram_rd`  out  1  read strobe.
- `ram_rdata`  in  16  read data, valid exactly RD_LAT cycles after the `ram_rd` cycle, for one cycle.
- `line_data`  out  16  fetched row; drives the sprite `data_in` whenever any `line_en` bit is high.
- `line_en`  out  NSPR  one-hot load strobe, one cycle per fetched sprite.
- `busy`  out  1  high while state != IDLE.
- `overrun`  out  1  sticky: `linebegin` arrived while busy.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- States: IDLE, SETTLE, ISSUE, WAIT.
- IDLE → SETTLE on `linebegin`. SETTLE lasts one cycle so sprite engines can advance their row addresses. During SETTLE the block latches `spr_en` into `pend`.
- SETTLE → ISSUE with `idx` = lowest set bit of `pend`. If `pend` == 0, SETTLE → IDLE.
- ISSUE (1 cycle): `ram_rd`=1, `ram_addr`=`spr_addr[idx]`, wait counter := RD_LAT, go to WAIT.
- WAIT (RD_LAT cycles): counter decrements. On the last WAIT cycle the block registers `line_data` := `ram_rdata`, `line_en` := onehot(idx), and clears `pend[idx]`. It then goes to ISSUE for the next set bit, or to IDLE if none remain.
- `ram_addr` is a combinational mux on `idx` in every state. `ram_rd` is 0 outside ISSUE.
- `line_en` is high for exactly one cycle per capture. Otherwise it is 0, and `line_data` holds its last value.
- `linebegin` while busy (any non-IDLE state, including the final capture cycle):
  - abort the current walk with no capture and no `line_en`;
  - set `overrun`;
  - restart at SETTLE with a fresh `spr_en` sample.
- `overrun`: set by an abort, cleared by `overrun_clr`. If both happen in the same cycle, set wins.
- Reset values: state IDLE, `idx` 0, `pend` 0, `line_data` 0, `line_en` 0, `ram_rd` 0, `overrun` 0, `busy` 0. A reset mid-walk aborts silently, with no `line_en` pulse.

## Timing
- `linebegin` at cycle T: SETTLE at T+1, first ISSUE at T+2, first `line_en` at T+2+RD_LAT+1.
- Per enabled sprite: 1+RD_LAT cycles. Disabled sprites cost 0 cycles.
- Next ISSUE coincides with the previous sprite's `line_en` cycle.
- Total walk with k enabled sprites: `busy` high T+1 .. T+1+k(1+RD_LAT). The last `line_en` falls one cycle after `busy` drops.
- NSPR=4, RD_LAT=1, all enabled: `line_en` pulses at T+4, T+6, T+8, T+10; `busy` high T+1..T+9.
- Integration requirement: horizontal blanking must be at least 2+NSPR(1+RD_LAT) cycles. The CPU data path must not write sprite registers while any `line_en` bit is high; the fetcher has priority on `data_in`.

## Structure
- Shared package `vga_pkg` holds:
  - the state enum (IDLE, SETTLE, ISSUE, WAIT);
  - `SPR_DATA_W` = 16;
  - the default sprite RAM base `SPRITE_MEM_LOC` = 9'h0a0.
- One sub-module, `sprite_next_sel`: a combinational priority encoder taking `pend` to {`found`, `next_idx`}. It is reused by the SETTLE and WAIT transitions.
- Counter width is clog2(RD_LAT+1). `idx` width is clog2(NSPR), minimum 1.

## Test plan
- NSPR=4, RD_LAT=1, `spr_en`=4'hF, `spr_addr`={0x0a3,0x0a2,0x0a1,0x0a0}, RAM returns the address as data, `linebegin` at T: `ram_rd` at T+2/4/6/8 with matching addresses; `line_en`=1,2,4,8 at T+4/6/8/10 with `line_data`=0x00a0..0x00a3.
- `spr_en`=4'b1010: only sprites 1 and 3 are read; `line_en`=2 at T+4 and 8 at T+6; `busy` falls after T+5.
- `spr_en`=0: `busy` high at T+1 only; no `ram_rd`, no `line_en`.
- RD_LAT=3, all enabled: `line_en` at T+6, T+10, T+14, T+18; a stale `ram_rdata` value in non-capture cycles is never loaded.
- Second `linebegin` at T+5 (mid-walk): no `line_en` from the aborted walk after T+5; `overrun`=1; new walk `line_en` at T+9…; `overrun_clr` together with a new abort leaves `overrun`=1; `overrun_clr` alone clears it.
- `rst` asserted at T+3: all outputs 0 next cycle, no `line_en`; after release the next `linebegin` runs a normal walk.
